serial_sixteen_bit_subtractor: RTL

//   Bit-serial A - B unit: the inverse of the combinational sixteenBitAdder.

---
 rtl/serial_sixteen_bit_subtractor.sv | 100 ++++++++++
 1 files changed

// File: rtl/serial_sixteen_bit_subtractor.sv
// Bit-serial unsigned subtractor: latches a/b on start, resolves one difference
// bit per clock LSB first, then presents diff/borrow with a one-cycle done pulse.
module serial_sixteen_bit_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] ra_q;
    logic [WIDTH-1:0] rb_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q;
    logic             br_d;
    logic             bit_d;
    logic             busy_q;
    logic             done_q;
    logic             borrow_q;

    // Full-subtractor on the current LSBs; the new bit enters the shift register at the top.
    always_comb begin
        bit_d = ra_q[0] ^ rb_q[0] ^ br_q;
        br_d  = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & br_q);
        sr_d  = {bit_d, sr_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ra_q     <= '0;
            rb_q     <= '0;
            sr_q     <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ra_q    <= a;
                        rb_q    <= b;
                        cnt_q   <= '0;
                        br_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr_q <= sr_d;
                    br_q <= br_d;
                    ra_q <= ra_q >> 1;
                    rb_q <= rb_q >> 1;
                    if (cnt_q == LAST) begin
                        diff_q   <= sr_d;
                        borrow_q <= br_d;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule
